// File: rtl/pool_ctrl.sv
// pool_ctrl: 2x2 stride-2 signed max pooling over a CHW feature map in DRAM.
// Each output window is built from four reads (RD) followed by one write
// (WR). Reads return data one cycle after the address, so the running max
// lags the read index by one and the last compare happens in WR.
module pool_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] OFMAP_BASE = 18'd131072,
  parameter logic [ADDR_WIDTH-1:0] POOL_BASE  = 18'd196608
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [4:0]            num_chnl,
  input  logic [5:0]            fmap_height,
  input  logic [5:0]            fmap_width,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  dram_en_rd,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  dram_en_wr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    RD   = 4'b0010,
    WR   = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t state, state_nxt;

  // Dimensions latched on an accepted start; held until the next start.
  logic [4:0] nch_q, pw_q, ph_q;
  // Window scan position and read index inside the window.
  logic [4:0] ch_q, py_q, px_q;
  logic [1:0] k_q;
  logic [DATA_WIDTH-1:0] max_q;

  logic dims_ok, last_px, last_py, last_ch, last_win;
  logic [DATA_WIDTH-1:0] max_fwd;
  logic [17:0] rd_word, wr_word;

  // Low bits of the dimensions only matter for the dropped odd row/column.
  logic unused_lsb;
  assign unused_lsb = fmap_width[0] ^ fmap_height[0];

  assign dims_ok  = (num_chnl != 5'd0) && (fmap_width[5:1] != 5'd0) &&
                    (fmap_height[5:1] != 5'd0);
  assign last_px  = (px_q == pw_q - 5'd1);
  assign last_py  = (py_q == ph_q - 5'd1);
  assign last_ch  = (ch_q == nch_q - 5'd1);
  assign last_win = last_px && last_py && last_ch;

  // Equal operands forward the running max; the values are identical anyway.
  assign max_fwd = ($signed(data_in) > $signed(max_q)) ? data_in : max_q;

  // Row coordinate 2*py+dy and column 2*px+dx are formed by appending k bits.
  assign rd_word = {4'd0, ch_q[3:0], py_q[3:0], k_q[1], px_q[3:0], k_q[0]};
  assign wr_word = {4'd0, ch_q[3:0], py_q, px_q};

  // State register.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others, regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: a default is assigned before the case so no path leaves state_nxt
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = dims_ok ? RD : DONE;
      RD:      if (k_q == 2'd3) state_nxt = WR;
      WR:      state_nxt = last_win ? DONE : RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Dimension latch, scan counters and running max.
  always_ff @(posedge clk) begin
    if (srst) begin
      nch_q <= '0;
      pw_q  <= '0;
      ph_q  <= '0;
      ch_q  <= '0;
      py_q  <= '0;
      px_q  <= '0;
      k_q   <= '0;
      max_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            nch_q <= num_chnl;
            pw_q  <= fmap_width[5:1];
            ph_q  <= fmap_height[5:1];
            ch_q  <= '0;
            py_q  <= '0;
            px_q  <= '0;
            k_q   <= '0;
          end
        end
        RD: begin
          k_q <= k_q + 2'd1;
          if (k_q == 2'd1)      max_q <= data_in;
          else if (k_q != 2'd0) max_q <= max_fwd;
        end
        WR: begin
          if (!last_px) begin
            px_q <= px_q + 5'd1;
          end else begin
            px_q <= '0;
            if (!last_py) begin
              py_q <= py_q + 5'd1;
            end else begin
              py_q <= '0;
              ch_q <= ch_q + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // DRAM strobes, addresses and status decoded from the current state.
  always_comb begin
    addr_in    = '0;
    dram_en_rd = 1'b0;
    addr_out   = '0;
    data_out   = '0;
    dram_en_wr = 1'b0;
    busy       = (state != IDLE);
    done       = (state == DONE);
    if (state == RD) begin
      addr_in    = OFMAP_BASE + ADDR_WIDTH'(rd_word);
      dram_en_rd = 1'b1;
    end
    if (state == WR) begin
      addr_out   = POOL_BASE + ADDR_WIDTH'(wr_word);
      data_out   = max_fwd;
      dram_en_wr = 1'b1;
    end
  end

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, DRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 18, DRAM address width.
REQ-003 SHALL have parameter OFMAP_BASE, default 18'd131072, base of conv output region read by this block.
REQ-004 SHALL have parameter POOL_BASE, default 18'd196608, base of pooled output region written by this block.
REQ-005 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-006 SHALL have port srst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port enable, input, 1, start request, sampled only in IDLE.
REQ-008 SHALL have port num_chnl, input, 5, channel count 0..16, latched on accepted enable.
REQ-009 SHALL have port fmap_height, input, 6, ofmap height 0..32, latched on accepted enable.
REQ-010 SHALL have port fmap_width, input, 6, ofmap width 0..32, latched on accepted enable.
REQ-011 SHALL have port data_in, input, DATA_WIDTH, DRAM read data, signed two's complement, valid 1 cycle after read address.
REQ-012 SHALL have port addr_in, output, ADDR_WIDTH, DRAM read address.
REQ-013 SHALL have port dram_en_rd, output, 1, read strobe.
REQ-014 SHALL have port addr_out, output, ADDR_WIDTH, DRAM write address.
REQ-015 SHALL have port data_out, output, DATA_WIDTH, DRAM write data.
REQ-016 SHALL have port dram_en_wr, output, 1, write strobe.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-019 SHALL perform 2x2 stride-2 signed max pooling over a num_chnl x fmap_height x fmap_width map.
REQ-020 SHALL use one-hot FSM states IDLE, RD, WR, DONE.
- IDLE->RD on enable, with valid dims.
- RD->WR after 4th read.
- WR->RD if windows remain; WR->DONE after last window.
- DONE->IDLE unconditionally.
REQ-021 SHALL compute windows per row PW = fmap_width[5:1] and rows PH = fmap_height[5:1]; odd last column/row dropped.
REQ-022 SHALL go IDLE->DONE directly on enable if num_chnl==0, PW==0 or PH==0, with no DRAM access.
REQ-023 SHALL scan px fastest, then py, then channel, starting at (0,0,0).
REQ-024 SHALL issue per window 4 RD cycles with window index k=0..3 and (dx,dy) = (0,0),(1,0),(0,1),(1,1).
REQ-025 SHALL drive in RD addr_in = OFMAP_BASE + {4'd0, chnl[3:0], 2*py+dy (5b), 2*px+dx (5b)} and dram_en_rd=1.
REQ-026 SHALL drive addr_in=0 and dram_en_rd=0 outside RD.
REQ-027 SHALL load running max from data_in in the RD cycle with k=1.
REQ-028 SHALL update running max to signed max(max, data_in) in RD cycles with k=2 and k=3.
REQ-029 SHALL in WR drive dram_en_wr=1, data_out = signed max(running max, data_in), addr_out = POOL_BASE + {4'd0, chnl[3:0], py[4:0], px[4:0]}.
REQ-030 SHALL drive addr_out=0, data_out=0, dram_en_wr=0 outside WR.
REQ-031 SHALL take 5 cycles per window, giving throughput 1 write per 5 cycles.
REQ-032 SHALL give total latency from enable-accept to done = 5*num_chnl*PH*PW + 1 cycles.
REQ-033 SHALL ignore enable while not in IDLE and SHALL keep latched dims stable until IDLE.
REQ-034 SHALL allow either operand to be forwarded on equal compare operands, since values are identical.
REQ-035 SHALL accept a new enable in the cycle after DONE.

Reset
REQ-036 SHALL on srst=1 at a clock edge enter IDLE and clear all counters, running max and latched dims.
REQ-037 SHALL hold every output 0 after reset: addr_in, addr_out, data_out, dram_en_rd, dram_en_wr, busy, done.
REQ-038 SHALL on srst mid-operation discard the in-flight window, produce no further writes, and restart from window (0,0,0) on next enable.

Verification
REQ-039 SHALL cover: 1 chnl, 2x2, values 3,-7,9,1 -> reads 131072,131073,131104,131105; one write addr 196608 data 9; done 6 cycles after enable.
REQ-040 SHALL cover: values -5,-2,-9,-3 -> write data -2, checking the signed compare.
REQ-041 SHALL cover: 2 chnl, 4x4 -> 8 writes in order 196608,196609,196640,196641,197632,197633,197664,197665; done at cycle 41.
REQ-042 SHALL cover: width 5, height 2, 1 chnl -> 2 writes only, column 4 never read.
REQ-043 SHALL cover: num_chnl=0 -> done 1 cycle after enable, dram_en_rd/dram_en_wr never asserted.
REQ-044 SHALL cover: srst during RD k=2 -> all outputs 0 next cycle; no write occurs; re-enable rereads address 131072 first.
